mult_datapath: RTL and testbench

Arithmetic datapath of the sequential 8x8 multiplier, directly downstream of `mult_control`. It consumes the controller's `input_sel`, `shift_sel`, `clk_ena`, `sclr_n` and `done`, and feeds back the 2-bit step counter `count`. It builds the 16-bit product from four 4x4 partial products accumulated over four steps, then holds the final result in an output register with a valid/ready handshake.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult4x4.sv | 10 +
 rtl/mult_datapath.sv | 88 ++++++++
 tb/tb_mult_datapath.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: encodings and widths shared by mult_control and mult_datapath.
package mult_pkg;
    localparam int OP_W   = 8;
    localparam int NIB_W  = 4;
    localparam int PROD_W = 16;
    typedef enum logic [1:0] {
        SEL_LL = 2'b00,
        SEL_LH = 2'b01,
        SEL_HL = 2'b10,
        SEL_HH = 2'b11
    } input_sel_e;
    typedef enum logic [1:0] {
        SH_0    = 2'b00,
        SH_4    = 2'b01,
        SH_8    = 2'b10,
        SH_ZERO = 2'b11
    } shift_sel_e;
endpackage

// File: rtl/mult4x4.sv
// mult4x4: combinational unsigned 4x4 multiplier with 8-bit product.
module mult4x4
    import mult_pkg::*;
(
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    output logic [2*NIB_W-1:0] p
);
    assign p = {{NIB_W{1'b0}}, a} * {{NIB_W{1'b0}}, b};
endmodule

// File: rtl/mult_datapath.sv
// mult_datapath: sequential 8x8 multiplier datapath with valid/ready result register.
// Define MULT_DP_OPERAND_LATCH_EN to register operands on start.
module mult_datapath
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset_a,
    input  logic              start,
    input  logic [OP_W-1:0]   dataa,
    input  logic [OP_W-1:0]   datab,
    input  logic [1:0]        input_sel,
    input  logic [1:0]        shift_sel,
    input  logic              clk_ena,
    input  logic              sclr_n,
    input  logic              done,
    output logic [1:0]        count,
    output logic [PROD_W-1:0] product8x8,
    output logic [PROD_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              result_lost
);
    logic [OP_W-1:0]   a_op, b_op;
    logic [NIB_W-1:0]  a_nib, b_nib;
    logic [2*NIB_W-1:0] pp;
    logic [PROD_W-1:0] shifted;
    logic [PROD_W-1:0] acc_q, acc_d, res_q, res_d;
    logic [1:0]        count_q, count_d;
    logic              valid_q, valid_d, lost_q, lost_d, capture;

`ifdef MULT_DP_OPERAND_LATCH_EN
    logic [OP_W-1:0] opa_q, opb_q;
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            opa_q <= '0;
            opb_q <= '0;
        end else if (start) begin
            opa_q <= dataa;
            opb_q <= datab;
        end
    end
    assign a_op = opa_q;
    assign b_op = opb_q;
`else
    assign a_op = dataa;
    assign b_op = datab;
`endif

    // input_sel bit 1 picks the high nibble of A, bit 0 the high nibble of B
    assign a_nib = input_sel[1] ? a_op[7:4] : a_op[3:0];
    assign b_nib = input_sel[0] ? b_op[7:4] : b_op[3:0];

    mult4x4 u_mult4x4 (.a(a_nib), .b(b_nib), .p(pp));

    always_comb begin
        shifted = (shift_sel == SH_0) ? {8'b0, pp} :
                  (shift_sel == SH_4) ? {4'b0, pp, 4'b0} :
                  (shift_sel == SH_8) ? {pp, 8'b0} : '0;
        acc_d   = clk_ena ? (sclr_n ? acc_q + shifted : shifted) : acc_q;
        count_d = start ? 2'd0 : count_q + 2'd1;
        capture = done && (!valid_q || result_ready);
        res_d   = capture ? acc_q : res_q;
        valid_d = capture ? 1'b1 : (valid_q && !result_ready ? 1'b1 : (done && valid_q));
        lost_d  = lost_q || (done && valid_q && !result_ready);
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            acc_q   <= '0;
            count_q <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            lost_q  <= lost_d;
        end
    end

    assign count        = count_q;
    assign product8x8   = acc_q;
    assign result       = res_q;
    assign result_valid = valid_q;
    assign result_lost  = lost_q;
endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: table vectors, hand sequences and random stimulus against a product-level model.
module tb_mult_datapath;
    logic        clk = 0;
    logic        reset_a = 0;
    logic        start = 0, clk_ena = 0, sclr_n = 0, done = 0, result_ready = 0;
    logic [7:0]  dataa = 0, datab = 0;
    logic [1:0]  input_sel = 0, shift_sel = 0;
    logic [1:0]  count;
    logic [15:0] product8x8, result;
    logic        result_valid, result_lost;

    int checks = 0, errors = 0;
    int m_acc = 0, m_cnt = 0, m_res = 0, m_valid = 0, m_lost = 0, m_opa = 0, m_opb = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[6];

    mult_datapath dut (
        .clk(clk), .reset_a(reset_a), .start(start), .dataa(dataa), .datab(datab),
        .input_sel(input_sel), .shift_sel(shift_sel), .clk_ena(clk_ena), .sclr_n(sclr_n),
        .done(done), .count(count), .product8x8(product8x8), .result(result),
        .result_valid(result_valid), .result_ready(result_ready), .result_lost(result_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int partial(input int a, input int b, input int isel, input int ssel);
        int an, bn;
        an = (isel >= 2) ? a / 16 : a % 16;
        bn = (isel % 2 == 1) ? b / 16 : b % 16;
        return (ssel == 3) ? 0 : an * bn * (1 << (4 * ssel));
    endfunction

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_res = 0; m_valid = 0; m_lost = 0; m_opa = 0; m_opb = 0;
    endtask

    task automatic check_all();
        check("count", count, m_cnt);
        check("product8x8", product8x8, m_acc);
        check("result", result, m_res);
        check("result_valid", result_valid, m_valid);
        check("result_lost", result_lost, m_lost);
    endtask

    task automatic tick();
        int a, b, p;
        logic st, en, sc, dn, rdy;
        logic [1:0] is, ss;
`ifdef MULT_DP_OPERAND_LATCH_EN
        a = m_opa; b = m_opb;
`else
        a = dataa; b = datab;
`endif
        st = start; en = clk_ena; sc = sclr_n; dn = done; rdy = result_ready; is = input_sel; ss = shift_sel;
        p = partial(a, b, is, ss);
        @(posedge clk);
        if (st) begin m_opa = dataa; m_opb = datab; end
        if (dn && (!m_valid || rdy)) begin m_res = m_acc; m_valid = 1; end
        else if (dn) m_lost = 1;
        else if (m_valid && rdy) m_valid = 0;
        if (en) m_acc = sc ? (m_acc + p) % 65536 : p;
        m_cnt = st ? 0 : (m_cnt + 1) % 4;
        #1;
        check_all();
    endtask

    task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input logic [7:0] a_late, input bit hold);
        logic [4:0] steps[4];
        steps[0] = 5'b0_00_00; steps[1] = 5'b1_01_01; steps[2] = 5'b1_10_01; steps[3] = 5'b1_11_10;
        dataa = a; datab = b; start = 1; clk_ena = 0; done = 0;
        tick();
        start = 0; dataa = a_late;
        for (int i = 0; i < 4; i++) begin
            if (hold && i == 2) begin
                clk_ena = 0; sclr_n = 0;
                repeat (3) tick();
            end
            {sclr_n, input_sel, shift_sel} = steps[i];
            clk_ena = 1;
            tick();
        end
        clk_ena = 0; done = 1;
        tick();
        done = 0;
    endtask

    initial begin
        vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[1] = '{8'd12, 8'd10, 16'h0078};
        vecs[2] = '{8'h00, 8'hAB, 16'h0000};
        vecs[3] = '{8'h10, 8'h10, 16'h0100};
        vecs[4] = '{8'h80, 8'h02, 16'h0100};
        vecs[5] = '{8'hA5, 8'h3C, 16'h26AC};

        #1;
        check("reset_count", count, 0);
        check("reset_product", product8x8, 0);
        check("reset_result", result, 0);
        check("reset_valid", result_valid, 0);
        check("reset_lost", result_lost, 0);
        #8 reset_a = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("count_seq", count, (i + 1) % 4);
        end

        result_ready = 1;
        for (int i = 0; i < 6; i++) begin
            run_mult(vecs[i].a, vecs[i].b, vecs[i].a, i == 1);
            check("vec_product", product8x8, vecs[i].exp);
            check("vec_result", result, vecs[i].exp);
            check("vec_valid", result_valid, 1);
        end
        tick();
        check("handshake_drop", result_valid, 0);

        result_ready = 0;
        run_mult(8'd3, 8'd5, 8'd3, 0);
        check("blk_first_result", result, 15);
        check("blk_first_valid", result_valid, 1);
        run_mult(8'd7, 8'd9, 8'd7, 0);
        check("blk_second_result", result, 15);
        check("blk_lost", result_lost, 1);
        result_ready = 1;
        tick();
        check("blk_drain_valid", result_valid, 0);
        check("blk_lost_sticky", result_lost, 1);

        run_mult(8'h11, 8'h0D, 8'h22, 0);
`ifdef MULT_DP_OPERAND_LATCH_EN
        check("latch_product", product8x8, 16'h11 * 16'h0D);
`else
        check("live_product", product8x8, 16'h22 * 16'h0D);
`endif

        start = 1; done = 1;
        tick();
        check("start_done_count", count, 0);
        check("start_done_valid", result_valid, 1);
        start = 0; done = 0;

        clk_ena = 1; sclr_n = 0; input_sel = 2'b11; shift_sel = 2'b10; dataa = 8'hFF; datab = 8'hFF;
        tick();
        #2 reset_a = 0;
        #1;
        check("midreset_count", count, 0);
        check("midreset_product", product8x8, 0);
        check("midreset_result", result, 0);
        check("midreset_valid", result_valid, 0);
        check("midreset_lost", result_lost, 0);
        model_reset();
        #2 reset_a = 1;

        for (int i = 0; i < 300; i++) begin
            start = ($urandom_range(0, 7) == 0);
            clk_ena = $urandom_range(0, 1);
            sclr_n = ($urandom_range(0, 3) != 0);
            done = ($urandom_range(0, 4) == 0);
            result_ready = $urandom_range(0, 1);
            input_sel = 2'($urandom_range(0, 3));
            shift_sel = 2'($urandom_range(0, 3));
            dataa = 8'($urandom);
            datab = 8'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
